// File: rtl/dbg_scan_ctrl.sv
// Debug scan controller: it reads one address per divider tick from the selected channel and latches the result for display.
// Optional end-of-scan marker slot: define DBG_SCAN_WRAP_MARK_EN.
module dbg_scan_ctrl #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned AW       = 6,
    parameter int unsigned DW       = 32,
    parameter int unsigned DIV_FAST = 25,
    parameter int unsigned DIV_SLOW = 27,
    parameter int unsigned TMO      = 15
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NCH-1:0]        ch_en_i,
    input  logic                  slow_i,
    input  logic                  cpu_run_i,
    input  logic [NCH*AW-1:0]     lim_i,
    output logic                  rd_req_o,
    output logic [$clog2(NCH)-1:0] rd_ch_o,
    output logic [AW-1:0]         rd_addr_o,
    input  logic                  rd_ack_i,
    input  logic [DW-1:0]         rd_data_i,
    output logic [DW-1:0]         disp_data_o,
    output logic [$clog2(NCH)-1:0] disp_ch_o,
    output logic [AW-1:0]         disp_addr_o,
    output logic                  disp_valid_o,
    output logic                  cpu_ce_o
);

    localparam int unsigned CW = $clog2(NCH);
    localparam logic [7:0]  TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE} state_e;

    logic [DIV_SLOW:0] div_q;
    logic              bit_q;
    logic              slow_q;
    logic              cpu_ce_q;
    logic              sel_bit;
    logic              tick;

    state_e            state_q;
    logic [CW-1:0]     ch_q;
    logic [AW-1:0]     rd_addr_q;
    logic              rd_req_q;
    logic [7:0]        tmo_q;
    logic [AW-1:0]     addr_q [NCH];
    logic [DW-1:0]     disp_data_q;
    logic [CW-1:0]     disp_ch_q;
    logic [AW-1:0]     disp_addr_q;
    logic              disp_valid_q;
`ifdef DBG_SCAN_WRAP_MARK_EN
    logic [NCH-1:0]    mark_q;
    logic [AW-1:0]     lim_sel;
`endif

    logic [CW-1:0]     sel_idx;
    logic [3:0]        ones;
    logic              ch_ok;
    logic [AW-1:0]     lim_cur;
    logic [AW-1:0]     adv_d;
    logic              wrap_d;

    // Tick is masked in the cycle slow_i changes, so bit_q has already followed the new bit next cycle.
    assign sel_bit = slow_i ? div_q[DIV_SLOW] : div_q[DIV_FAST];
    assign tick    = sel_bit & ~bit_q & (slow_i == slow_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q    <= '0;
            bit_q    <= 1'b0;
            slow_q   <= 1'b0;
            cpu_ce_q <= 1'b0;
        end else begin
            div_q    <= div_q + 1'b1;
            bit_q    <= sel_bit;
            slow_q   <= slow_i;
            cpu_ce_q <= tick & cpu_run_i;
        end
    end

    always_comb begin
        ones    = '0;
        sel_idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (ch_en_i[i]) begin
                ones    = ones + 1'b1;
                sel_idx = CW'(i);
            end
        end
        ch_ok = (ones == 4'd1);
    end

    // Any address at or above its limit wraps, which also recovers registers left above a lowered limit.
    always_comb begin
        lim_cur = lim_i[int'(ch_q)*AW +: AW];
        wrap_d  = (addr_q[ch_q] >= lim_cur);
        adv_d   = wrap_d ? '0 : addr_q[ch_q] + 1'b1;
    end

`ifdef DBG_SCAN_WRAP_MARK_EN
    assign lim_sel = lim_i[int'(sel_idx)*AW +: AW];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            rd_addr_q    <= '0;
            rd_req_q     <= 1'b0;
            tmo_q        <= '0;
            disp_data_q  <= '0;
            disp_ch_q    <= '0;
            disp_addr_q  <= '0;
            disp_valid_q <= 1'b0;
            for (int unsigned i = 0; i < NCH; i++) addr_q[i] <= '0;
`ifdef DBG_SCAN_WRAP_MARK_EN
            mark_q       <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick && ch_ok) begin
`ifdef DBG_SCAN_WRAP_MARK_EN
                        if (mark_q[sel_idx]) begin
                            mark_q[sel_idx] <= 1'b0;
                            disp_data_q     <= '1;
                            disp_valid_q    <= 1'b0;
                            disp_ch_q       <= sel_idx;
                            disp_addr_q     <= lim_sel + 1'b1;
                        end else
`endif
                        begin
                            state_q   <= ST_REQ;
                            ch_q      <= sel_idx;
                            rd_addr_q <= addr_q[sel_idx];
                            rd_req_q  <= 1'b1;
                            tmo_q     <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (rd_ack_i) begin
                        disp_data_q  <= rd_data_i;
                        disp_valid_q <= 1'b1;
                        disp_ch_q    <= ch_q;
                        disp_addr_q  <= rd_addr_q;
                        rd_req_q     <= 1'b0;
                        state_q      <= ST_DONE;
                    end else if (tmo_q == TMO_LAST) begin
                        disp_data_q  <= '1;
                        disp_valid_q <= 1'b0;
                        rd_req_q     <= 1'b0;
                        state_q      <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    addr_q[ch_q] <= adv_d;
`ifdef DBG_SCAN_WRAP_MARK_EN
                    if (wrap_d) mark_q[ch_q] <= 1'b1;
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_req_o     = rd_req_q;
    assign rd_ch_o      = ch_q;
    assign rd_addr_o    = rd_addr_q;
    assign disp_data_o  = disp_data_q;
    assign disp_ch_o    = disp_ch_q;
    assign disp_addr_o  = disp_addr_q;
    assign disp_valid_o = disp_valid_q;
    assign cpu_ce_o     = cpu_ce_q;

endmodule
